// File: rtl/radar_wave_ctrl.sv
// Radar waveform controller: accepts a validated waveform/timing config, then
// sequences LOAD/ON/OFF phases and drives the waveform generator's control signals.
module radar_wave_ctrl #(
  parameter int CNT_W = 24
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_wave,
  input  logic [3:0]       cfg_mode,
  input  logic [31:0]      cfg_fw,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_chirp,
  input  logic             run,
  output logic [5:0]       wave_sel,
  output logic [3:0]       mode_sel,
  output logic [31:0]      Fw1,
  output logic             judge,
  output logic             T_cnt,
  output logic             T_cnt_flag,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ON   = 2'd2,
    S_OFF  = 2'd3
  } state_t;

  // Config handshake: a transfer happens on any edge where cfg_valid && cfg_ready;
  // cfg_ready is low only during the single LOAD cycle.
  state_t             state_q, state_d;
  logic               loaded_q, loaded_d;
  logic [2:0]         sh_wave_q, sh_wave_d;
  logic [3:0]         sh_mode_q, sh_mode_d;
  logic [31:0]        sh_fw_q, sh_fw_d;
  logic [CNT_W-1:0]   sh_period_q, sh_period_d;
  logic [CNT_W-1:0]   sh_width_q, sh_width_d;
  logic [CNT_W-1:0]   sh_chirp_q, sh_chirp_d;
  logic [CNT_W-1:0]   pri_cnt_q, pri_cnt_d;
  logic [CNT_W-1:0]   chirp_cnt_q, chirp_cnt_d;
  logic [5:0]         wave_sel_q, wave_sel_d;
  logic [3:0]         mode_sel_q, mode_sel_d;
  logic [31:0]        fw1_q, fw1_d;
  logic               judge_q, judge_d;
  logic               t_cnt_q, t_cnt_d;
  logic               t_cnt_flag_q, t_cnt_flag_d;
  logic               err_q, err_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               hs, cfg_ok;
  logic [CNT_W-1:0]   chirp_last;

  always_comb begin
    state_d     = state_q;
    loaded_d    = loaded_q;
    sh_wave_d   = sh_wave_q;
    sh_mode_d   = sh_mode_q;
    sh_fw_d     = sh_fw_q;
    sh_period_d = sh_period_q;
    sh_width_d  = sh_width_q;
    sh_chirp_d  = sh_chirp_q;
    pri_cnt_d   = pri_cnt_q;
    chirp_cnt_d = chirp_cnt_q;
    wave_sel_d  = wave_sel_q;
    mode_sel_d  = mode_sel_q;
    fw1_d       = fw1_q;
    chirp_last  = sh_chirp_q - CNT_W'(1);

    hs     = cfg_valid && cfg_ready_q;
    cfg_ok = (cfg_wave <= 3'd5) && (cfg_fw != 32'd0) &&
             ((cfg_wave != 3'd2) || (cfg_chirp != '0)) &&
             ((cfg_mode == 4'd1) ||
              ((cfg_period >= CNT_W'(2)) && (cfg_width != '0) && (cfg_width <= cfg_period)));
    err_d  = hs && !cfg_ok;

    if (hs && cfg_ok) begin
      sh_wave_d   = cfg_wave;
      sh_mode_d   = cfg_mode;
      sh_fw_d     = cfg_fw;
      sh_period_d = cfg_period;
      sh_width_d  = cfg_width;
      sh_chirp_d  = cfg_chirp;
      loaded_d    = 1'b1;
      state_d     = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: if (run && loaded_q) state_d = S_LOAD;
        S_LOAD: begin
          if (run) begin
            state_d     = S_ON;
            pri_cnt_d   = '0;
            chirp_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          if (!run) begin
            state_d = S_IDLE;
          end else begin
            if (sh_mode_q == 4'd1) begin
              pri_cnt_d = '0;
              state_d   = S_ON;
            end else begin
              pri_cnt_d = (pri_cnt_q == sh_period_q - CNT_W'(1)) ? '0 : pri_cnt_q + CNT_W'(1);
              state_d   = (pri_cnt_d < sh_width_q) ? S_ON : S_OFF;
            end
            // Chirp count restarts at each new pulse and freezes while off.
            if (state_d == S_ON) begin
              if (state_q == S_OFF) chirp_cnt_d = '0;
              else chirp_cnt_d = (chirp_cnt_q == chirp_last) ? '0 : chirp_cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end

    if (state_d == S_LOAD) begin
      wave_sel_d = 6'd1 << sh_wave_d;
      mode_sel_d = sh_mode_d;
      fw1_d      = sh_fw_d;
    end

    judge_d      = (state_d == S_IDLE) || (state_d == S_LOAD);
    cfg_ready_d  = (state_d != S_LOAD);
    t_cnt_d      = (state_d == S_OFF);
    t_cnt_flag_d = (sh_wave_q == 3'd2) && (state_d == S_ON) &&
                   ((chirp_cnt_d == chirp_last) || (state_q == S_OFF));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      loaded_q     <= 1'b0;
      sh_wave_q    <= 3'd0;
      sh_mode_q    <= 4'd1;
      sh_fw_q      <= 32'd0;
      sh_period_q  <= '0;
      sh_width_q   <= '0;
      sh_chirp_q   <= '0;
      pri_cnt_q    <= '0;
      chirp_cnt_q  <= '0;
      wave_sel_q   <= 6'b000001;
      mode_sel_q   <= 4'd1;
      fw1_q        <= 32'd0;
      judge_q      <= 1'b1;
      t_cnt_q      <= 1'b0;
      t_cnt_flag_q <= 1'b0;
      err_q        <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      sh_wave_q    <= sh_wave_d;
      sh_mode_q    <= sh_mode_d;
      sh_fw_q      <= sh_fw_d;
      sh_period_q  <= sh_period_d;
      sh_width_q   <= sh_width_d;
      sh_chirp_q   <= sh_chirp_d;
      pri_cnt_q    <= pri_cnt_d;
      chirp_cnt_q  <= chirp_cnt_d;
      wave_sel_q   <= wave_sel_d;
      mode_sel_q   <= mode_sel_d;
      fw1_q        <= fw1_d;
      judge_q      <= judge_d;
      t_cnt_q      <= t_cnt_d;
      t_cnt_flag_q <= t_cnt_flag_d;
      err_q        <= err_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign wave_sel   = wave_sel_q;
  assign mode_sel   = mode_sel_q;
  assign Fw1        = fw1_q;
  assign judge      = judge_q;
  assign T_cnt      = t_cnt_q;
  assign T_cnt_flag = t_cnt_flag_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_radar_wave_ctrl.sv
// Bench for radar_wave_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a phase/time-based model.
module tb_radar_wave_ctrl;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [2:0]       cfg_wave = '0;
  logic [3:0]       cfg_mode = '0;
  logic [31:0]      cfg_fw = '0;
  logic [CNT_W-1:0] cfg_period = '0, cfg_width = '0, cfg_chirp = '0;
  logic             run = 1'b0;
  logic [5:0]       wave_sel;
  logic [3:0]       mode_sel;
  logic [31:0]      Fw1;
  logic             judge, T_cnt, T_cnt_flag, err;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  radar_wave_ctrl #(.CNT_W(CNT_W)) dut (
    .sys_clk(clk), .sys_rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_wave(cfg_wave), .cfg_mode(cfg_mode), .cfg_fw(cfg_fw),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_chirp(cfg_chirp),
    .run(run), .wave_sel(wave_sel), .mode_sel(mode_sel), .Fw1(Fw1),
    .judge(judge), .T_cnt(T_cnt), .T_cnt_flag(T_cnt_flag), .err(err), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0=idle, 1=load, 2=active; m_t counts cycles since the active phase began.
  int          m_ph = 0;
  int          m_t = 0;
  bit          m_loaded = 0;
  int          sh_wave = 0, sh_mode = 1, sh_period = 0, sh_width = 0, sh_chirp = 0;
  logic [31:0] sh_fw = 0;
  logic [5:0]  e_wave = 6'd1;
  logic [3:0]  e_mode = 4'd1;
  logic [31:0] e_fw = 0;
  bit          e_err = 0;
  bit          chk_en = 0;

  function automatic bit cfg_ok_f(int w, int m, logic [31:0] fw, int p, int wd, int c);
    return (w <= 5) && (fw != 0) && (w != 2 || c >= 1) &&
           (m == 1 || (p >= 2 && wd >= 1 && wd <= p));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_t = 0; m_loaded = 0;
      e_wave = 6'd1; e_mode = 4'd1; e_fw = 0; e_err = 0;
      chk_en = 1;
    end else begin
      automatic bit hs = cfg_valid && (m_ph != 1);
      automatic bit ok = cfg_ok_f(int'(cfg_wave), int'(cfg_mode), cfg_fw,
                                  int'(cfg_period), int'(cfg_width), int'(cfg_chirp));
      e_err = hs && !ok;
      if (hs && ok) begin
        sh_wave = int'(cfg_wave); sh_mode = int'(cfg_mode); sh_fw = cfg_fw;
        sh_period = int'(cfg_period); sh_width = int'(cfg_width); sh_chirp = int'(cfg_chirp);
        m_loaded = 1;
        m_ph = 1;
      end else begin
        case (m_ph)
          0: if (run && m_loaded) m_ph = 1;
          1: if (run) begin m_ph = 2; m_t = 0; end else m_ph = 0;
          default: if (!run) m_ph = 0; else m_t++;
        endcase
      end
      if (m_ph == 1) begin
        e_wave = 6'd1 << sh_wave;
        e_mode = 4'(sh_mode);
        e_fw   = sh_fw;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      automatic int  e_state = m_ph;
      automatic bit  e_flag = 0;
      if (m_ph == 2) begin
        automatic bit pulsed = (sh_mode != 1);
        automatic int pri = pulsed ? (m_t % sh_period) : 0;
        automatic bit on  = !pulsed || (pri < sh_width);
        automatic int seg = (!pulsed || sh_width == sh_period) ? m_t : pri;
        e_state = on ? 2 : 3;
        if (sh_wave == 2 && on && sh_chirp > 0)
          e_flag = ((seg % sh_chirp) == sh_chirp - 1) ||
                   (pulsed && sh_width < sh_period && pri == 0 && m_t > 0);
      end
      chk("state", 32'(state), 32'(e_state));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ph != 1));
      chk("judge", 32'(judge), 32'(m_ph != 2));
      chk("T_cnt", 32'(T_cnt), 32'(e_state == 3));
      chk("T_cnt_flag", 32'(T_cnt_flag), 32'(e_flag));
      chk("err", 32'(err), 32'(e_err));
      chk("wave_sel", 32'(wave_sel), 32'(e_wave));
      chk("mode_sel", 32'(mode_sel), 32'(e_mode));
      chk("Fw1", Fw1, e_fw);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int w, input int m, input logic [31:0] fw,
                         input int p, input int wd, input int c);
    cfg_wave = 3'(w); cfg_mode = 4'(m); cfg_fw = fw;
    cfg_period = CNT_W'(p); cfg_width = CNT_W'(wd); cfg_chirp = CNT_W'(c);
  endtask

  task automatic send_cfg(input int w, input int m, input logic [31:0] fw,
                          input int p, input int wd, input int c);
    set_cfg(w, m, fw, p, wd, c);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    for (int i = 0; i < 30 && state != s; i++) @(negedge clk);
    chk(name, 32'(state), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int flags, first, tsum;
    logic [19:0] pat;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_wave", 32'(wave_sel), 32'(6'b000001));
    chk("rst_mode", 32'(mode_sel), 1);
    chk("rst_ready", 32'(cfg_ready), 1);

    // LFM continuous: flag on every 8th ON cycle
    run = 1'b1;
    send_cfg(2, 1, 32'h100, 0, 0, 8);
    chk("lfm_judge", 32'(judge), 1);
    chk("lfm_wave", 32'(wave_sel), 32'(6'b000100));
    chk("lfm_load", 32'(state), 1);
    flags = 0; first = -1; tsum = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (T_cnt_flag) begin
        flags++;
        if (first < 0) first = i;
      end
      tsum += int'(T_cnt);
    end
    chk("lfm_flags", 32'(flags), 3);
    chk("lfm_first", 32'(first), 7);
    chk("lfm_tcnt", 32'(tsum), 0);

    // Pulsed period 10, width 3
    send_cfg(0, 0, 32'd5, 10, 3, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pat[i] = T_cnt;
    end
    chk("pulse_pattern", 32'(pat), 32'(20'b11111110001111111000));
    chk("pulse_judge", 32'(judge), 0);

    // run low alone: IDLE, judge high, Fw1 held
    run = 1'b0;
    @(negedge clk);
    chk("stop_state", 32'(state), 0);
    chk("stop_judge", 32'(judge), 1);
    chk("stop_fw", Fw1, 32'd5);

    // width > period rejected
    send_cfg(0, 0, 32'd9, 10, 11, 1);
    chk("bad_err", 32'(err), 1);
    chk("bad_state", 32'(state), 0);
    chk("bad_ready", 32'(cfg_ready), 1);
    chk("bad_fw", Fw1, 32'd5);
    @(negedge clk);
    chk("bad_err_clr", 32'(err), 0);

    // New QPSK config during OFF
    run = 1'b1;
    send_cfg(0, 0, 32'd5, 10, 3, 1);
    wait_state(2'd3, "wait_off");
    send_cfg(4, 0, 32'd7, 6, 2, 1);
    chk("qpsk_load", 32'(state), 1);
    chk("qpsk_wave", 32'(wave_sel), 32'(6'b010000));
    @(negedge clk);
    chk("qpsk_on", 32'(state), 2);
    chk("qpsk_tcnt", 32'(T_cnt), 0);

    // run low with valid handshake in ON: handshake wins
    wait_state(2'd2, "wait_on");
    run = 1'b0;
    send_cfg(1, 1, 32'd3, 0, 0, 0);
    chk("race_load", 32'(state), 1);
    chk("race_wave", 32'(wave_sel), 32'(6'b000010));
    @(negedge clk);
    chk("race_idle", 32'(state), 0);

    // Reset mid-pulse, then run alone must not restart
    run = 1'b1;
    send_cfg(2, 0, 32'd9, 10, 4, 2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_fw", Fw1, 0);
    chk("mid_rst_wave", 32'(wave_sel), 32'(6'b000001));
    chk("mid_rst_tcnt", 32'(T_cnt), 0);
    repeat (5) @(negedge clk);
    chk("no_restart", 32'(state), 0);

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      automatic int p = $urandom_range(0, 9) == 0 ? $urandom_range(0, 1) : $urandom_range(2, 12);
      automatic int m = ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(0, 15);
      set_cfg($urandom_range(0, 6), m, ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom,
              p, $urandom_range(0, p + 1), $urandom_range(0, 6));
      cfg_valid = ($urandom_range(0, 24) == 0);
      run = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
